// File: rtl/input_conditioner.sv
// Switch/key front end: 2-FF synchronizers, per-bit debounce, edge pulses,
// key auto-repeat FSM and a wrapping press counter. All outputs are registered.
module input_conditioner #(
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_SW-1:0] SW,
  input  logic            KEY_N,
  input  logic            repeat_en,
  output logic [N_SW-1:0] sw_stable,
  output logic            key_n_stable,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            sw_changed,
  output logic [7:0]      press_count
);

  localparam int NB    = N_SW + 1;
  localparam int DW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] stable;

  // The key rides along as the top bit so it shares the switch debouncer.
  assign raw = {KEY_N, SW};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bit
      localparam logic RST_VAL = (gi == N_SW);
      logic          s1_reg;
      logic          s2_reg;
      logic          stable_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          s1_reg     <= RST_VAL;
          s2_reg     <= RST_VAL;
          stable_reg <= RST_VAL;
          cnt_reg    <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            stable_reg <= s2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  assign sw_stable    = stable[N_SW-1:0];
  assign key_n_stable = stable[N_SW];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            press_reg, press_next;
  logic            release_reg, release_next;
  logic [7:0]      count_reg, count_next;
  logic [N_SW-1:0] sw_prev_reg;
  logic            sw_changed_reg;
  logic            key_prev_reg;
  logic            key_fall;
  logic            key_rise;

  assign key_fall = key_prev_reg & ~key_n_stable;
  assign key_rise = ~key_prev_reg & key_n_stable;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      press_reg      <= 1'b0;
      release_reg    <= 1'b0;
      count_reg      <= '0;
      sw_prev_reg    <= '0;
      sw_changed_reg <= 1'b0;
      key_prev_reg   <= 1'b1;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      press_reg      <= press_next;
      release_reg    <= release_next;
      count_reg      <= count_next;
      sw_prev_reg    <= sw_stable;
      sw_changed_reg <= |(sw_stable ^ sw_prev_reg);
      key_prev_reg   <= key_n_stable;
    end
  end

  // A release always wins, even over a timer expiry in the same cycle.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    if (key_rise) begin
      release_next = 1'b1;
      state_next   = ST_IDLE;
      timer_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (key_fall) begin
            press_next = 1'b1;
            timer_next = '0;
            state_next = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (repeat_en) begin
            if (timer_reg == DELAY_LAST) begin
              press_next = 1'b1;
              timer_next = '0;
              state_next = ST_REPEAT;
            end else begin
              timer_next = timer_reg + TW'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (!repeat_en) begin
            timer_next = '0;
            state_next = ST_DELAY;
          end else if (timer_reg == PERIOD_LAST) begin
            press_next = 1'b1;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          timer_next = '0;
        end
      endcase
    end
    count_next = count_reg + {7'd0, press_next};
  end

  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign sw_changed    = sw_changed_reg;
  assign press_count   = count_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues expected pulse edges,
// a negedge monitor pops and compares whenever a pulse output is high.
module tb_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic       key_n;
  logic       repeat_en;
  logic [7:0] sw_stable;
  logic       key_n_stable;
  logic       press_pulse;
  logic       release_pulse;
  logic       sw_changed;
  logic [7:0] press_count;

  input_conditioner #(
    .N_SW(8),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .Clk(clk),
    .Reset(reset),
    .SW(sw),
    .KEY_N(key_n),
    .repeat_en(repeat_en),
    .sw_stable(sw_stable),
    .key_n_stable(key_n_stable),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .sw_changed(sw_changed),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
  } exp_t;

  exp_t       press_q[$];
  exp_t       rel_q[$];
  exp_t       swc_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] cnt_exp = 8'd0;
  logic [7:0] sw_exp = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, req);
    end else
      $display("ok   %s at edge %0d: value=%0h", name, cyc, act);
  endtask

  // k: 0 press, 1 release, 2 sw_changed
  task automatic check_kind(input int k, input string name, input logic pulse, input logic [7:0] data);
    exp_t e;
    int   n;
    n = (k == 0) ? press_q.size() : (k == 1) ? rel_q.size() : swc_q.size();
    if (n > 0) e = (k == 0) ? press_q[0] : (k == 1) ? rel_q[0] : swc_q[0];
    if (pulse || (n > 0 && e.edge_n <= cyc)) begin
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL %s: unexpected pulse at edge %0d data=%0h, none required", name, cyc, data);
      end else begin
        case (k)
          0: void'(press_q.pop_front());
          1: void'(rel_q.pop_front());
          default: void'(swc_q.pop_front());
        endcase
        if (!pulse || e.edge_n != cyc || data !== e.data) begin
          failures++;
          $display("FAIL %s: actual pulse=%0b edge=%0d data=%0h, required edge=%0d data=%0h",
                   name, pulse, cyc, data, e.edge_n, e.data);
        end else
          $display("ok   %s: edge=%0d data=%0h", name, cyc, data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_kind(0, "press_pulse", press_pulse, press_count);
      check_kind(1, "release_pulse", release_pulse, {7'd0, press_pulse});
      check_kind(2, "sw_changed", sw_changed, sw_stable);
    end
  end

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic push_press(input int e);
    exp_t x;
    cnt_exp++;
    x.edge_n = e;
    x.data   = cnt_exp;
    press_q.push_back(x);
  endtask

  task automatic push_rel(input int e);
    exp_t x;
    x.edge_n = e;
    x.data   = 8'd0;
    rel_q.push_back(x);
  endtask

  task automatic push_swc(input int e, input logic [7:0] v);
    exp_t x;
    x.edge_n = e;
    x.data   = v;
    swc_q.push_back(x);
  endtask

  // New switch level driven now is stable D+2 edges later; pulse one edge after that.
  task automatic set_sw(input logic [7:0] v);
    int c;
    c  = cyc;
    sw = v;
    if (v != sw_exp) push_swc(c + D + 3, v);
    sw_exp = v;
    wait_until(c + D + 6);
  endtask

  // Press now, release driven after edge c+hold; repeat_en held at 1.
  task automatic key_cycle(input int hold);
    int c, r, p;
    c     = cyc;
    r     = c + hold;
    key_n = 1'b0;
    p     = c + D + 3;
    push_press(p);
    if (p + 10 <= r + D + 2) begin
      p += 10;
      push_press(p);
      while (p + 3 <= r + D + 2) begin
        p += 3;
        push_press(p);
      end
    end
    wait_until(r);
    key_n = 1'b1;
    push_rel(r + D + 3);
    wait_until(r + D + 6);
  endtask

  initial begin
    int c, e0;
    #(200000 * 10);
    $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e0;
    // Reset with inputs already asserted
    reset     = 1'b1;
    sw        = 8'hFF;
    key_n     = 1'b0;
    repeat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sw_stable", {24'd0, sw_stable}, 32'h0);
      chk("rst_key_n_stable", {31'd0, key_n_stable}, 32'h1);
      chk("rst_pulses", {29'd0, press_pulse, release_pulse, sw_changed}, 32'h0);
      chk("rst_press_count", {24'd0, press_count}, 32'h0);
    end
    reset = 1'b0;
    c = cyc;
    push_swc(c + 7, 8'hFF);
    push_press(c + 7);
    push_press(c + 17);
    wait_until(c + 5);
    chk("sw_before_accept", {24'd0, sw_stable}, 32'h0);
    wait_until(c + 6);
    chk("sw_at_edge6", {24'd0, sw_stable}, 32'hFF);
    chk("key_at_edge6", {31'd0, key_n_stable}, 32'h0);
    wait_until(c + 11);
    key_n = 1'b1;
    push_rel(c + 18);
    wait_until(c + 21);
    sw_exp = 8'hFF;

    // Plain switch changes
    set_sw(8'h3C);
    set_sw(8'h81);
    set_sw(8'h3C);

    // Bounce rejection on bit 0
    for (int i = 0; i < 20; i++) begin
      sw = {7'h1E, ((i % 4) < 2) ? 1'b1 : 1'b0};
      @(negedge clk);
    end
    chk("bounce_no_change", {24'd0, sw_stable}, 32'h3C);
    c  = cyc;
    sw = 8'h3D;
    push_swc(c + 7, 8'h3D);
    sw_exp = 8'h3D;
    wait_until(c + 5);
    chk("bounce_before_rise", {31'd0, sw_stable[0]}, 32'h0);
    wait_until(c + 6);
    chk("bounce_rise_edge6", {31'd0, sw_stable[0]}, 32'h1);
    wait_until(c + 10);

    // Auto-repeat: held 30 cycles after acceptance
    key_cycle(36);
    // Release accepted as the DELAY timer reaches its last count
    key_cycle(10);
    // Short press, no repeats
    key_cycle(8);

    // repeat_en low: single press, then resume
    c         = cyc;
    repeat_en = 1'b0;
    key_n     = 1'b0;
    push_press(c + 7);
    e0 = c + 46;
    wait_until(e0);
    repeat_en = 1'b1;
    push_press(e0 + 10);
    push_press(e0 + 13);
    push_press(e0 + 16);
    push_press(e0 + 19);
    wait_until(e0 + 14);
    key_n = 1'b1;
    push_rel(e0 + 21);
    wait_until(e0 + 25);

    // Idle reset: held switches re-debounce from zero
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_press_count", {24'd0, press_count}, 32'h0);
    chk("rst2_sw_stable", {24'd0, sw_stable}, 32'h0);
    reset   = 1'b0;
    cnt_exp = 8'd0;
    c       = cyc;
    push_swc(c + 7, sw_exp);
    wait_until(c + 10);
    set_sw(8'hA5);

    // 256 presses wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      key_cycle(6);
      checks++;
      if (sw_stable !== 8'hA5) begin
        failures++;
        $display("FAIL wrap_sw_stable iter %0d: actual=%0h required=a5", i, sw_stable);
      end
    end
    chk("wrap_press_count", {24'd0, press_count}, 32'h0);

    wait_until(cyc + 20);
    chk("press_q_drained", press_q.size(), 32'd0);
    chk("rel_q_drained", rel_q.size(), 32'd0);
    chk("swc_q_drained", swc_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
